// File: rtl/axis_dma_frame_packer.sv
// AXI4-Stream frame packer: buffers input words in a FIFO and cuts them into TLAST-bounded DMA frames.
// Defining FRAME_PACKER_TIMEOUT_EN adds the TIMEOUT_CYCLES port and the idle-timeout FLUSH state.
module axis_dma_frame_packer #(
   parameter int TDATA_WIDTH     = 128,
   parameter int FIFO_DEPTH_LOG2 = 4,
   parameter int FRAME_LEN_WIDTH = 16,
   parameter int TIMEOUT_WIDTH   = 16
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic [TDATA_WIDTH-1:0]     S_AXIS_TDATA,
   input  logic [TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
   input  logic                       S_AXIS_TVALID,
   input  logic                       S_AXIS_TLAST,
   output logic                       S_AXIS_TREADY,
   output logic [TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
   output logic                       M_AXIS_TVALID,
   output logic                       M_AXIS_TLAST,
   input  logic                       M_AXIS_TREADY,
   input  logic [FRAME_LEN_WIDTH-1:0] FRAME_LEN_WORDS,
`ifdef FRAME_PACKER_TIMEOUT_EN
   input  logic [TIMEOUT_WIDTH-1:0]   TIMEOUT_CYCLES,
`endif
   output logic [31:0]                FRAME_COUNT
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int KW    = TDATA_WIDTH / 8;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;
   localparam logic [CW-1:0]              CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]              CNT_TWO  = CW'(2);
   localparam logic [CW-1:0]              CNT_FULL = CW'(DEPTH);
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
   localparam logic [FRAME_LEN_WIDTH-1:0] LEN_ONE  = FRAME_LEN_WIDTH'(1);

`ifdef FRAME_PACKER_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1} state_t;
`endif

   state_t                     state_q;
   logic [TDATA_WIDTH-1:0]     data_mem_q [DEPTH];
   logic [KW-1:0]              keep_mem_q [DEPTH];
   logic [DEPTH-1:0]           last_mem_q;
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]              count_q, count_d;
   logic [FRAME_LEN_WIDTH-1:0] word_cnt_q, len_lat_q;
   logic [31:0]                frame_cnt_q;
`ifdef FRAME_PACKER_TIMEOUT_EN
   logic [TIMEOUT_WIDTH-1:0]   idle_cnt_q;
`endif

   logic                       full, push, pop, pop_last, in_flush, head_last;
   logic [FRAME_LEN_WIDTH-1:0] len_now, len_eff;

`ifdef FRAME_PACKER_TIMEOUT_EN
   assign in_flush = (state_q == FLUSH);
`else
   assign in_flush = 1'b0;
`endif

   // Valid/ready: a word moves when VALID and READY are both high at a rising edge;
   // a source holding VALID keeps its word stable until it is taken.
   assign full          = (count_q == CNT_FULL);
   assign S_AXIS_TREADY = !full && !in_flush && !ARESET;
   assign push          = S_AXIS_TVALID && S_AXIS_TREADY;

   // The frame length is live until the first word of a frame leaves, then frozen.
   assign len_now   = (FRAME_LEN_WORDS == '0) ? LEN_ONE : FRAME_LEN_WORDS;
   assign len_eff   = (word_cnt_q == '0) ? len_now : len_lat_q;
   assign head_last = last_mem_q[rd_ptr_q] || (word_cnt_q == len_eff - LEN_ONE)
                      || (in_flush && count_q == CNT_ONE);

   // The newest word is held back until it is known whether it ends the frame.
   assign M_AXIS_TVALID = !ARESET && ((count_q >= CNT_TWO) || (count_q == CNT_ONE && head_last));
   assign M_AXIS_TLAST  = M_AXIS_TVALID && head_last;
   assign M_AXIS_TDATA  = data_mem_q[rd_ptr_q];
   assign M_AXIS_TKEEP  = keep_mem_q[rd_ptr_q];
   assign FRAME_COUNT   = frame_cnt_q;

   assign pop      = M_AXIS_TVALID && M_AXIS_TREADY;
   assign pop_last = pop && head_last;

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_mem_q[i] <= '1;
            keep_mem_q[i] <= '0;
         end
         last_mem_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         if (push) begin
            data_mem_q[wr_ptr_q] <= S_AXIS_TDATA;
            keep_mem_q[wr_ptr_q] <= S_AXIS_TKEEP;
            last_mem_q[wr_ptr_q] <= S_AXIS_TLAST;
            wr_ptr_q             <= wr_ptr_q + PTR_ONE;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_d;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= IDLE;
         word_cnt_q  <= '0;
         len_lat_q   <= LEN_ONE;
         frame_cnt_q <= '0;
`ifdef FRAME_PACKER_TIMEOUT_EN
         idle_cnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE:   if (push) state_q <= ACTIVE;
            ACTIVE: begin
               if (pop_last && count_q == CNT_ONE && !push) state_q <= IDLE;
`ifdef FRAME_PACKER_TIMEOUT_EN
               else if (TIMEOUT_CYCLES != '0 && idle_cnt_q == TIMEOUT_CYCLES && count_q != '0)
                  state_q <= FLUSH;
`endif
            end
`ifdef FRAME_PACKER_TIMEOUT_EN
            FLUSH:  if (pop_last && count_q == CNT_ONE) state_q <= IDLE;
`endif
            default: state_q <= IDLE;
         endcase

`ifdef FRAME_PACKER_TIMEOUT_EN
         if (push || state_q != ACTIVE)  idle_cnt_q <= '0;
         else if (idle_cnt_q != '1)      idle_cnt_q <= idle_cnt_q + TIMEOUT_WIDTH'(1);
`endif

         if (pop) begin
            word_cnt_q <= head_last ? '0 : word_cnt_q + LEN_ONE;
            if (word_cnt_q == '0) len_lat_q <= len_now;
         end
         if (pop_last) frame_cnt_q <= frame_cnt_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_axis_dma_frame_packer.sv
// Bench for axis_dma_frame_packer: directed frame-cutting scenarios and randomized frames under
// random backpressure, scored against a frame-position reference model.
module tb_axis_dma_frame_packer;

   localparam int DW = 128;
   localparam int KW = DW / 8;
   localparam int LW = 16;
   localparam int TW = 16;
   localparam int EW = 1 + KW + DW;

   logic          ACLK = 1'b0;
   logic          ARESET = 1'b1;
   logic [DW-1:0] S_AXIS_TDATA = '0;
   logic [KW-1:0] S_AXIS_TKEEP = '0;
   logic          S_AXIS_TVALID = 1'b0;
   logic          S_AXIS_TLAST = 1'b0;
   logic          S_AXIS_TREADY;
   logic [DW-1:0] M_AXIS_TDATA;
   logic [KW-1:0] M_AXIS_TKEEP;
   logic          M_AXIS_TVALID;
   logic          M_AXIS_TLAST;
   logic          M_AXIS_TREADY = 1'b0;
   logic [LW-1:0] FRAME_LEN_WORDS = 16'd4;
`ifdef FRAME_PACKER_TIMEOUT_EN
   logic [TW-1:0] TIMEOUT_CYCLES = '0;
`endif
   logic [31:0]   FRAME_COUNT;

   axis_dma_frame_packer #(
      .TDATA_WIDTH(DW), .FIFO_DEPTH_LOG2(4), .FRAME_LEN_WIDTH(LW), .TIMEOUT_WIDTH(TW)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP), .S_AXIS_TVALID(S_AXIS_TVALID),
      .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
      .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TVALID(M_AXIS_TVALID),
      .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
      .FRAME_LEN_WORDS(FRAME_LEN_WORDS),
`ifdef FRAME_PACKER_TIMEOUT_EN
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
`endif
      .FRAME_COUNT(FRAME_COUNT)
   );

   // ---------------- clock / reset ----------------
   int cyc = 0;
   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: run still going at %0t, required to finish", $time);
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int            errors = 0;
   int            checks = 0;
   int            pos = 0;
   int            cur_len = 1;
   int            model_frames = 0;
   int            push_cyc = 0;
   int            last_pop_cyc = 0;
   logic          last_pop_sready = 1'b1;
   bit            rand_bp = 1'b0;
   logic          tready_cmd = 1'b1;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endtask

   // Reference model: position within the current frame decides TLAST.
   task automatic model_push(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
      bit is_last;
      if (pos == 0) cur_len = (FRAME_LEN_WORDS == '0) ? 1 : int'(FRAME_LEN_WORDS);
      pos++;
      is_last = l || (pos == cur_len);
      if (is_last) pos = 0;
      exp_q.push_back({is_last, k, d});
   endtask

   // An idle timeout closes the frame on whatever word is buffered last.
   task automatic model_flush();
      logic [EW-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_back();
         e[EW-1] = 1'b1;
         exp_q.push_back(e);
      end
      pos = 0;
   endtask

   // ---------------- drivers ----------------
   always @(negedge ACLK) M_AXIS_TREADY = rand_bp ? ($urandom_range(0, 3) != 0) : tready_cmd;

   task automatic send_word(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                            input int budget, output bit ok);
      @(negedge ACLK);
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = d;
      S_AXIS_TKEEP  = k;
      S_AXIS_TLAST  = l;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (S_AXIS_TREADY) begin
            ok = 1'b1;
            break;
         end
         @(negedge ACLK);
      end
      if (ok) begin
         push_cyc = cyc;
         model_push(d, k, l);
      end else begin
         S_AXIS_TVALID = 1'b0;
      end
   endtask

   task automatic idle_cycles(input int n);
      @(negedge ACLK);
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      repeat (n - 1) @(negedge ACLK);
   endtask

   task automatic do_reset(input int n);
      @(negedge ACLK);
      ARESET = 1'b1;
      S_AXIS_TVALID = 1'b0;
      exp_q.delete();
      pos = 0;
      #1;
      check("rst_s_tready", S_AXIS_TREADY, 0);
      check("rst_m_tvalid", M_AXIS_TVALID, 0);
      repeat (n) @(negedge ACLK);
      ARESET = 1'b0;
      #1;
      check("post_rst_m_tvalid", M_AXIS_TVALID, 0);
      check("post_rst_frame_count", FRAME_COUNT, 0);
      check("post_rst_tdata", M_AXIS_TDATA, {DW{1'b1}});
      check("post_rst_tkeep", M_AXIS_TKEEP, 0);
      check("post_rst_s_tready", S_AXIS_TREADY, 1);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge ACLK);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d words still pending after %0d cycles, expected 0", name, exp_q.size(), n);
      end
      repeat (3) @(negedge ACLK);
   endtask

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- monitor ----------------
   logic [EW-1:0] act_e, exp_e, held_e;
   logic          stalled = 1'b0;

   initial begin : monitor
      forever begin
         @(negedge ACLK);
         #2;
         act_e = {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA};
         if (ARESET) begin
            stalled = 1'b0;
            model_frames = 0;
         end else begin
            if (stalled) begin
               check("hold_valid", M_AXIS_TVALID, 1);
               check("hold_word", act_e, held_e);
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_out: got %0h, expected no word", act_e);
               end else begin
                  exp_e = exp_q.pop_front();
                  if (act_e !== exp_e) begin
                     errors++;
                     $display("FAIL out_word: got %0h, expected %0h", act_e, exp_e);
                  end
                  if (exp_e[EW-1]) model_frames++;
               end
               last_pop_cyc    = cyc;
               last_pop_sready = S_AXIS_TREADY;
            end
            stalled = M_AXIS_TVALID && !M_AXIS_TREADY;
            held_e  = act_e;
         end
      end
   end

   // ---------------- stimulus ----------------
   bit ok;
   int accepted;
   int n_words;

   initial begin : main
      do_reset(3);

      // Length cut: 12 words, frames of 4.
      tready_cmd = 1'b1;
      FRAME_LEN_WORDS = 16'd4;
      repeat (2) @(negedge ACLK);
      for (int i = 0; i < 12; i++) send_word(DW'(i), '1, 1'b0, 50, ok);
      idle_cycles(1);
      wait_drain("len_cut_drain", 100);
      check("len_cut_frames", FRAME_COUNT, 3);

      // Upstream end on word 2, then a full 8-word frame from a fresh count.
      do_reset(1);
      FRAME_LEN_WORDS = 16'd8;
      for (int i = 0; i < 3; i++) send_word(DW'(100 + i), '1, (i == 2), 50, ok);
      for (int i = 0; i < 8; i++) send_word(DW'(110 + i), 16'h00ff, 1'b0, 50, ok);
      idle_cycles(1);
      wait_drain("upstream_end_drain", 100);
      check("upstream_end_frames", FRAME_COUNT, 2);

`ifdef FRAME_PACKER_TIMEOUT_EN
      // Timeout flush: 5 words, then idle input.
      do_reset(1);
      TIMEOUT_CYCLES  = 16'd10;
      FRAME_LEN_WORDS = 16'd16;
      for (int i = 0; i < 5; i++) send_word(DW'(200 + i), '1, 1'b0, 50, ok);
      idle_cycles(1);
      model_flush();
      repeat (5) @(negedge ACLK);
      check("timeout_withheld_pending", exp_q.size(), 1);
      check("timeout_withheld_valid", M_AXIS_TVALID, 0);
      wait_drain("timeout_drain", 40);
      checks++;
      if (last_pop_cyc - push_cyc < 10 || last_pop_cyc - push_cyc > 14) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles, expected 10..14", last_pop_cyc - push_cyc);
      end
      check("timeout_s_tready_in_flush", last_pop_sready, 0);
      check("timeout_frames", FRAME_COUNT, 1);
      check("timeout_s_tready_after", S_AXIS_TREADY, 1);
      TIMEOUT_CYCLES = '0;
`else
      // No timeout: a trailing partial frame waits for more input.
      do_reset(1);
      FRAME_LEN_WORDS = 16'd8;
      for (int i = 0; i < 3; i++) send_word(DW'(200 + i), '1, 1'b0, 50, ok);
      idle_cycles(30);
      check("partial_wait_pending", exp_q.size(), 1);
      check("partial_wait_valid", M_AXIS_TVALID, 0);
      send_word(DW'(203), '1, 1'b1, 50, ok);
      idle_cycles(1);
      wait_drain("partial_wait_drain", 40);
      check("partial_wait_frames", FRAME_COUNT, 1);
`endif

      // Full FIFO with downstream stalled.
      do_reset(1);
      FRAME_LEN_WORDS = 16'd4;
      tready_cmd = 1'b0;
      repeat (2) @(negedge ACLK);
      accepted = 0;
      for (int i = 0; i < 20; i++) begin
         send_word(DW'(300 + i), '1, 1'b0, 3, ok);
         if (ok) accepted++;
      end
      idle_cycles(2);
      check("full_accepted", accepted, 16);
      check("full_s_tready", S_AXIS_TREADY, 0);
      check("full_head_valid", M_AXIS_TVALID, 1);
      check("full_head_word", M_AXIS_TDATA, DW'(300));
      tready_cmd = 1'b1;
      wait_drain("full_drain", 100);
      check("full_frames", FRAME_COUNT, 4);

      // Reset mid-frame discards the partial frame.
      FRAME_LEN_WORDS = 16'd4;
      for (int i = 0; i < 3; i++) send_word(DW'(400 + i), '1, 1'b0, 50, ok);
      idle_cycles(3);
      do_reset(1);
      for (int i = 0; i < 4; i++) send_word(DW'(500 + i), '1, 1'b0, 50, ok);
      idle_cycles(1);
      wait_drain("mid_reset_drain", 100);
      check("mid_reset_frames", FRAME_COUNT, 1);

      // Length change 4 -> 2 mid-frame affects only the next frame.
      do_reset(1);
      FRAME_LEN_WORDS = 16'd4;
      for (int i = 0; i < 3; i++) send_word(DW'(600 + i), '1, 1'b0, 50, ok);
      idle_cycles(4);
      check("len_change_pending", exp_q.size(), 1);
      FRAME_LEN_WORDS = 16'd2;
      for (int i = 3; i < 8; i++) send_word(DW'(600 + i), '1, 1'b0, 50, ok);
      idle_cycles(1);
      wait_drain("len_change_drain", 100);
      check("len_change_frames", FRAME_COUNT, 3);

      // Randomized frames, lengths (including 0) and backpressure.
      do_reset(2);
      rand_bp = 1'b1;
      for (int r = 0; r < 30; r++) begin
         FRAME_LEN_WORDS = LW'($urandom_range(0, 5));
         n_words = $urandom_range(1, 12);
         for (int i = 0; i < n_words; i++) begin
            send_word(rand_data(), KW'($urandom), (i == n_words - 1) || ($urandom_range(0, 7) == 0),
                      200, ok);
            checks++;
            if (!ok) begin
               errors++;
               $display("FAIL accept_timeout: word %0d of round %0d not accepted, expected accept", i, r);
            end
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
         end
         idle_cycles(1);
         wait_drain("rand_drain", 300);
      end
      rand_bp = 1'b0;
      tready_cmd = 1'b1;
      repeat (3) @(negedge ACLK);
      check("rand_frames", FRAME_COUNT, model_frames);
      check("rand_empty_valid", M_AXIS_TVALID, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
